// File: rtl/dmem_mmio_pkg.sv
// -----------------------------------------------------------------------------
// dmem_mmio_pkg
// Shared definitions for the data-memory / MMIO block of a single-cycle core:
// the memory map, the UART transmitter state encoding and the address decoder.
// -----------------------------------------------------------------------------
package dmem_mmio_pkg;

    localparam logic [31:0] RAM_BASE   = 32'h0000_0000;
    localparam logic [31:0] LED_ADDR   = 32'h0000_1000;
    localparam logic [31:0] UART_ADDR  = 32'h0000_1004;
    localparam logic [31:0] TIMER_ADDR = 32'h0000_1008;
    localparam int          RAM_WORDS  = 64;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_LED,
        SEL_UART,
        SEL_TIMER
    } sel_t;

    // Word-aligned decode: the two byte-offset bits never take part.
    function automatic sel_t decode(input logic [31:0] adr);
        sel_t sel;
        sel = SEL_NONE;
        if (adr[31:8] == RAM_BASE[31:8])
            sel = SEL_RAM;
        else if (adr[31:2] == LED_ADDR[31:2])
            sel = SEL_LED;
        else if (adr[31:2] == UART_ADDR[31:2])
            sel = SEL_UART;
        else if (adr[31:2] == TIMER_ADDR[31:2])
            sel = SEL_TIMER;
        return sel;
    endfunction

endpackage

// File: rtl/dmem_mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// 8N1 serial transmitter. A start pulse while idle latches the byte and sends
// start bit, eight data bits LSB first and one stop bit, each CLKS_PER_BIT
// clocks long. Starts while busy are ignored.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous, active-high
//   start  - request to send 'data' (honoured only when idle)
//   data   - byte to send
//   busy   - high while a frame is in progress
//   tx     - serial line, idle high, driven from a flop
// -----------------------------------------------------------------------------
module uart_tx
    import dmem_mmio_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    uart_state_t state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  data_q, data_d;
    logic        tx_q, tx_d;
    logic        baud_done;

    assign baud_done = (baud_q == BAUD_LAST);

    // tx_d is derived from the next state so the line changes on the same edge
    // as the state, keeping the output glitch-free and exactly bit-aligned.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        baud_d  = baud_q + 16'd1;
        bit_d   = bit_q;
        data_d  = data_q;
        tx_d    = tx_q;
        case (state_q)
            UART_IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (start) begin
                    state_d = UART_START;
                    data_d  = data;
                    tx_d    = 1'b0;
                end
            end
            UART_START: begin
                if (baud_done) begin
                    state_d = UART_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = data_q[0];
                end
            end
            UART_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = UART_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = data_q[bit_d];
                    end
                end
            end
            UART_STOP: begin
                if (baud_done) begin
                    state_d = UART_IDLE;
                    baud_d  = '0;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = UART_IDLE;
                baud_d  = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= UART_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
        end
    end

    assign busy = (state_q != UART_IDLE);
    assign tx   = tx_q;

endmodule

// File: rtl/dmem_mmio.sv
// -----------------------------------------------------------------------------
// dmem_mmio
// Data memory plus memory-mapped peripherals for a single-cycle core.
//   0x0000_0000..0x0000_00FF : 64 x 32 RAM
//   0x0000_1000              : LED register (8 bits)
//   0x0000_1004              : UART transmit (write = send byte, read = busy)
//   0x0000_1008              : free-running 32-bit timer (write = load)
// Ports:
//   clk       - clock, rising edge
//   reset     - asynchronous, active-high
//   MemWrite  - store strobe
//   DataAdr   - byte address (bits [1:0] ignored)
//   WriteData - store data
//   ReadData  - load data, combinational from DataAdr
//   LEDs      - LED register output
//   UartTx    - UART serial line, idle high
// -----------------------------------------------------------------------------
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  LEDs,
    output logic        UartTx
);

    sel_t        sel;
    logic [31:0] ram_mem [RAM_WORDS];
    logic [7:0]  leds_q, leds_d;
    logic [31:0] timer_q, timer_d;
    logic        uart_start;
    logic        uart_busy;
    logic [1:0]  unused_adr_lsbs;

    assign sel             = decode(DataAdr);
    assign unused_adr_lsbs = DataAdr[1:0];
    assign uart_start      = MemWrite && (sel == SEL_UART);

    // RAM write. The reset branch exists only so writes are blocked while
    // reset is high; the array itself keeps its contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: memory arrays are never reset; contents are undefined until written.
        end else if (MemWrite && (sel == SEL_RAM)) begin
            ram_mem[DataAdr[7:2]] <= WriteData;
        end
    end

    // A timer store replaces the increment for that cycle.
    always_comb begin
        leds_d  = leds_q;
        timer_d = timer_q + 32'd1;
        if (MemWrite) begin
            case (sel)
                SEL_LED:   leds_d  = WriteData[7:0];
                SEL_TIMER: timer_d = WriteData;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leds_q  <= '0;
            timer_q <= '0;
        end else begin
            leds_q  <= leds_d;
            timer_q <= timer_d;
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk   (clk),
        .reset (reset),
        .start (uart_start),
        .data  (WriteData[7:0]),
        .busy  (uart_busy),
        .tx    (UartTx)
    );

    always_comb begin
        case (sel)
            SEL_RAM:   ReadData = ram_mem[DataAdr[7:2]];
            SEL_LED:   ReadData = {24'b0, leds_q};
            SEL_UART:  ReadData = {31'b0, uart_busy};
            SEL_TIMER: ReadData = timer_q;
            default:   ReadData = '0;
        endcase
    end

    assign LEDs = leds_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// -----------------------------------------------------------------------------
// tb_dmem_mmio
// Randomised and directed stimulus against a behavioural model of the memory
// map. Each stimulus cycle pushes its expected ReadData / LEDs / UartTx values
// into a scoreboard queue; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_dmem_mmio;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    localparam int K_READ = 0;
    localparam int K_LEDS = 1;
    localparam int K_TX   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic [7:0]  LEDs;
    logic        UartTx;

    always #5 clk = ~clk;

    dmem_mmio #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .LEDs      (LEDs),
        .UartTx    (UartTx)
    );

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int cyc          = 0;
    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    logic [31:0] ram_m  [64];
    bit          ram_ok [64];
    logic [7:0]  leds_m      = '0;
    logic [31:0] timer_base  = '0;
    int          timer_cyc   = 0;
    int          frame_start = -1000;
    logic [7:0]  frame_byte  = '0;

    function automatic bit model_busy(input int n);
        return (n >= frame_start) && (n < frame_start + FRAME);
    endfunction

    // Line level n cycles into the frame: start bit, 8 data bits, stop bit.
    function automatic logic model_tx(input int n);
        int k;
        if (!model_busy(n)) return 1'b1;
        k = (n - frame_start) / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return frame_byte[k-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_timer(input int n);
        return timer_base + 32'(n - timer_cyc);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare everything scheduled for the current cycle.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            mon_e = sb_q.pop_front();
            if (mon_e.cyc < cyc) begin
                tests_run++;
                tests_failed++;
                $display("FAIL %s: stale entry for cycle %0d at cycle %0d", mon_e.name, mon_e.cyc, cyc);
            end else begin
                case (mon_e.kind)
                    K_READ:  check(mon_e.name, ReadData, mon_e.exp);
                    K_LEDS:  check(mon_e.name, {24'b0, LEDs}, mon_e.exp);
                    default: check(mon_e.name, {31'b0, UartTx}, mon_e.exp);
                endcase
            end
        end
    end

    // One bus cycle: drive inputs, push expectations, then apply the write.
    task automatic step(input logic rst_in, input logic we,
                        input logic [31:0] adr, input logic [31:0] wd);
        logic [31:0] rd_exp;
        bit          rd_ok;
        int          idx;
        exp_t        e;
        @(posedge clk);
        #1;
        cyc++;
        reset     = rst_in;
        MemWrite  = we;
        DataAdr   = adr;
        WriteData = wd;

        if (rst_in) begin
            leds_m      = '0;
            timer_base  = '0;
            timer_cyc   = cyc;
            frame_start = -1000;
        end

        rd_ok  = 1'b1;
        rd_exp = '0;
        idx    = int'(adr >> 2) % 64;
        if (adr < 32'h100) begin
            rd_ok  = ram_ok[idx];
            rd_exp = ram_m[idx];
        end else if ((adr & ~32'h3) == 32'h1000) begin
            rd_exp = {24'h0, leds_m};
        end else if ((adr & ~32'h3) == 32'h1004) begin
            rd_exp = {31'h0, model_busy(cyc)};
        end else if ((adr & ~32'h3) == 32'h1008) begin
            rd_exp = model_timer(cyc);
        end

        if (rd_ok) begin
            e = '{cyc, K_READ, rd_exp, $sformatf("read_data@%h", adr)};
            sb_q.push_back(e);
        end
        e = '{cyc, K_LEDS, {24'h0, leds_m}, "leds"};
        sb_q.push_back(e);
        e = '{cyc, K_TX, {31'h0, model_tx(cyc)}, "uart_tx"};
        sb_q.push_back(e);

        if (rst_in) begin
            timer_cyc = cyc + 1;
        end else if (we) begin
            if (adr < 32'h100) begin
                ram_m[idx]  = wd;
                ram_ok[idx] = 1'b1;
            end else if ((adr & ~32'h3) == 32'h1000) begin
                leds_m = wd[7:0];
            end else if ((adr & ~32'h3) == 32'h1004) begin
                if (!model_busy(cyc)) begin
                    frame_start = cyc + 1;
                    frame_byte  = wd[7:0];
                end
            end else if ((adr & ~32'h3) == 32'h1008) begin
                timer_base = wd;
                timer_cyc  = cyc + 1;
            end
        end
    endtask

    logic [31:0] unmapped [5] = '{32'h0000_0100, 32'h0000_2000, 32'h0000_100C,
                                  32'hFFFF_FFFC, 32'h0001_0000};

    initial begin
        logic [31:0] adr;
        logic        we;
        for (int i = 0; i < 64; i++) ram_ok[i] = 1'b0;

        // Reset state
        repeat (3) step(1'b1, 1'b0, 32'h0000_1008, '0);

        // RAM write then read-back; same-cycle write returns old data
        step(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 32'h0000_0010, '0);
        step(1'b0, 1'b1, 32'h0000_0014, 32'h1111_1111);
        step(1'b0, 1'b1, 32'h0000_0014, 32'h2222_2222);
        step(1'b0, 1'b0, 32'h0000_0017, '0);
        step(1'b0, 1'b1, 32'h0000_00FF, 32'h0BAD_F00D);
        step(1'b0, 1'b0, 32'h0000_00FC, '0);

        // LED register and unmapped read
        step(1'b0, 1'b1, 32'h0000_1000, 32'h0000_01A5);
        step(1'b0, 1'b0, 32'h0000_1000, '0);
        step(1'b0, 1'b1, 32'h0000_2000, 32'hFFFF_FFFF);
        step(1'b0, 1'b0, 32'h0000_2000, '0);

        // UART frame 0x55 with an ignored write of 0x12 while busy
        step(1'b0, 1'b1, 32'h0000_1004, 32'h0000_0055);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0000_1004, '0);
        step(1'b0, 1'b1, 32'h0000_1004, 32'h0000_0012);
        for (int i = 0; i < 34; i++) step(1'b0, 1'b0, 32'h0000_1004, '0);

        // Timer load and wrap
        step(1'b0, 1'b1, 32'h0000_1008, 32'hFFFF_FFFE);
        repeat (4) step(1'b0, 1'b0, 32'h0000_1008, '0);

        // Reset in the DATA state; writes during reset must be ignored
        step(1'b0, 1'b1, 32'h0000_1004, 32'h0000_00A3);
        for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 32'h0000_1004, '0);
        step(1'b1, 1'b0, 32'h0000_1008, '0);
        step(1'b1, 1'b0, 32'h0000_1004, '0);
        step(1'b1, 1'b1, 32'h0000_1000, 32'h0000_00FF);
        step(1'b1, 1'b1, 32'h0000_0010, 32'h0000_0000);
        step(1'b0, 1'b0, 32'h0000_0010, '0);
        step(1'b0, 1'b0, 32'h0000_1008, '0);

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 7))
                0, 1, 2: adr = 32'($urandom_range(0, 255));
                3:       adr = 32'h0000_1000 | 32'($urandom_range(0, 3));
                4:       adr = 32'h0000_1004;
                5:       adr = 32'h0000_1008;
                6:       adr = unmapped[$urandom_range(0, 4)];
                default: adr = 32'h0000_1000;
            endcase
            we = ($urandom_range(0, 3) == 0);
            step(($urandom_range(0, 199) == 0), we, adr, $urandom);
        end
        step(1'b0, 1'b0, 32'h0000_0000, '0);

        @(negedge clk);
        #1;
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dmem_mmio.md
DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, UART clock cycles per bit (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port MemWrite  input  1  store strobe from core, sampled on rising clk.
REQ-005 SHALL have port DataAdr  input  32  byte address from core ALU result.
REQ-006 SHALL have port WriteData  input  32  store data from core.
REQ-007 SHALL have port ReadData  output  32  load data to core, combinational from DataAdr.
REQ-008 SHALL have port LEDs  output  8  GPIO output register.
REQ-009 SHALL have port UartTx  output  1  serial transmit line, idle high.

Function
REQ-010 SHALL decode word-aligned addresses; DataAdr[1:0] ignored; byte/halfword access not supported.
REQ-011 SHALL map 0x0000_0000..0x0000_00FF to 64x32 RAM, word index DataAdr[7:2].
REQ-012 SHALL map 0x0000_1000 to LED register: write stores WriteData[7:0]; read returns {24'b0, LEDs}.
REQ-013 SHALL map 0x0000_1004 to UART: write starts frame with WriteData[7:0] only if transmitter IDLE; read returns {31'b0, busy}.
REQ-014 SHALL map 0x0000_1008 to timer: read returns 32-bit count; write loads WriteData.
REQ-015 SHALL return 0 on read of unmapped address; unmapped writes SHALL have no effect.
REQ-016 ReadData SHALL be purely combinational, valid same cycle as DataAdr (single-cycle core requirement).
REQ-017 Writes SHALL take effect on rising clk when MemWrite=1; read of same location in same cycle returns old value.
REQ-018 Timer SHALL increment by 1 every cycle, wrap 0xFFFF_FFFF->0; a write cycle loads WriteData instead of incrementing.
REQ-019 UART FSM states: IDLE, START, DATA, STOP.
REQ-020 IDLE: UartTx=1, busy=0; accepted write -> START next edge, data byte latched.
REQ-021 START: UartTx=0 for CLKS_PER_BIT cycles -> DATA.
REQ-022 DATA: bits 0..7 LSB first, CLKS_PER_BIT cycles each, 3-bit bit index -> STOP after bit 7.
REQ-023 STOP: UartTx=1 for CLKS_PER_BIT cycles -> IDLE.
REQ-024 busy SHALL equal (state != IDLE); UART write while busy SHALL be ignored, latched byte unchanged.
REQ-025 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles from first START cycle to first IDLE cycle.
REQ-026 Baud counter SHALL count 0..CLKS_PER_BIT-1 and clear on every state change.

Reset
REQ-027 Reset assertion SHALL immediately force LEDs=0, timer=0, UART state IDLE, UartTx=1, baud counter and bit index 0.
REQ-028 Reset mid-frame SHALL abort transmission; UartTx high with no glitch low.
REQ-029 RAM contents SHALL NOT be reset; RAM reads before first write undefined.
REQ-030 MemWrite during reset SHALL have no effect.

Structure
REQ-031 Shared package SHALL hold address constants (RAM_BASE, LED_ADDR, UART_ADDR, TIMER_ADDR) and UART state encoding.
REQ-032 UART transmitter SHALL be sub-module uart_tx (ports clk, reset, start, data[7:0], busy, tx), parameter CLKS_PER_BIT.
REQ-033 RAM, LED register, timer and address decode SHALL live in dmem_mmio.

Verification
REQ-034 Write 0xDEADBEEF to 0x0000_0010, then read 0x10 -> ReadData=0xDEADBEEF; read 0x14 same-cycle old value only.
REQ-035 Write 0x0000_01A5 to 0x1000 -> LEDs=0xA5 after edge; read 0x1000 -> 0x0000_00A5; read 0x2000 -> 0.
REQ-036 CLKS_PER_BIT=4, write 0x55 to 0x1004 -> UartTx 0,1,0,1,0,1,0,1,0,1 each 4 cycles; busy=1 for 40 cycles; read 0x1004 -> 1 then 0.
REQ-037 Write 0x12 to 0x1004 while busy -> frame continues with original byte, no second frame.
REQ-038 Write 0xFFFF_FFFE to 0x1008 -> reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000 on successive cycles.
REQ-039 Assert reset in DATA state -> UartTx=1, busy=0, LEDs=0, timer=0 immediately, without clock edge.
